nreg_write_arbiter: RTL



---
 rtl/nreg_write_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nreg_write_arbiter.sv
// Round-robin write arbiter sharing one enabled register among N requesters, with burst lock
// and idle timeout. Define NREG_ARB_WRITE_COUNT_EN to add the saturating io_write_count output.
module nreg_write_arbiter #(
    parameter int N            = 4,
    parameter int W            = 8,
    parameter int LOCK_TIMEOUT = 16,
    localparam int GW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    io_req_valid,
    input  logic [N-1:0]    io_req_lock,
    input  logic [N*W-1:0]  io_req_data,
    output logic [N-1:0]    io_req_ready,
    output logic [W-1:0]    io_reg_D,
    output logic            io_reg_enable,
    output logic [GW-1:0]   io_grant_id,
    output logic            io_locked
`ifdef NREG_ARB_WRITE_COUNT_EN
    ,
    output logic [15:0]     io_write_count
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam int CW      = $clog2(LOCK_TIMEOUT + 2);
    localparam int TO_LAST = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;

    logic [0:0]    state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] owner;
    logic [CW-1:0] idle_cnt;

    logic [GW-1:0] scan_id;
    logic          scan_hit;
    int            idx;

    logic          accept;
    logic [GW-1:0] acc_id;
    logic          acc_lock;
    logic [W-1:0]  acc_data;
    logic          timeout_hit;

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] cur);
        int nxt;
        nxt = int'(cur) + 1;
        if (nxt >= N) nxt = 0;
        return GW'(nxt);
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        scan_id  = '0;
        scan_hit = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!scan_hit && io_req_valid[idx]) begin
                scan_hit = 1'b1;
                scan_id  = GW'(idx);
            end
        end
    end

    always_comb begin
        io_req_ready = '0;
        if (!reset) begin
            if (state == IDLE) begin
                if (scan_hit) io_req_ready[scan_id] = 1'b1;
            end else begin
                io_req_ready[owner] = io_req_valid[owner];
            end
        end
    end

    assign accept      = |io_req_ready;
    assign acc_id      = (state == LOCKED) ? owner : scan_id;
    assign acc_lock    = io_req_lock[acc_id];
    assign acc_data    = io_req_data[acc_id*W +: W];
    assign timeout_hit = (LOCK_TIMEOUT > 0) && (idle_cnt == CW'(TO_LAST));
    assign io_locked   = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            io_reg_D      <= '0;
            io_reg_enable <= 1'b0;
            io_grant_id   <= '0;
            rr_ptr        <= '0;
            owner         <= '0;
            state         <= IDLE;
            idle_cnt      <= '0;
        end else begin
            io_reg_enable <= accept;
            if (accept) begin
                io_reg_D    <= acc_data;
                io_grant_id <= acc_id;
            end
            if (state == IDLE) begin
                if (accept) begin
                    if (acc_lock) begin
                        state    <= LOCKED;
                        owner    <= acc_id;
                        idle_cnt <= '0;
                    end else begin
                        rr_ptr <= next_ptr(acc_id);
                    end
                end
            end else if (accept) begin
                if (acc_lock) begin
                    idle_cnt <= '0;
                end else begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr(owner);
                end
            end else if (timeout_hit) begin
                // Owner went quiet too long: release without a write.
                state    <= IDLE;
                rr_ptr   <= next_ptr(owner);
                idle_cnt <= '0;
            end else if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

`ifdef NREG_ARB_WRITE_COUNT_EN
    logic [15:0] write_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            write_count_q <= '0;
        end else if (accept && (write_count_q != 16'hFFFF)) begin
            write_count_q <= write_count_q + 16'd1;
        end
    end

    assign io_write_count = write_count_q;
`endif

endmodule
